registrador_seq: RTL and testbench
==================================

// Module: registrador_seq
// PURPOSE
//   Sequencer for the registrador bank. It generates the shared ch0/ch1 control
//   code that all seven registrador instances decode.
//   - Applies one parallel-load cycle, then WIDTH shift steps at a programmable
//     rate; single-pass or looping.
//   - Sits beside the bank in main; replaces the two hand switches.
// PARAMETERS
//   WIDTH      14  register length; number of shift steps per pass
//   DIV_W      8   width of the rate divider configuration
// PORTS
//   clk        in   1       system clock; all flops on rising edge
//   rst_n      in   1       synchronous reset, active-low
//   start      in   1       begin a pass; sampled only in IDLE
//   stop       in   1       abort; sampled in every non-IDLE state
//   pause      in   1       level; freezes shifting while high (RUN only)
//   dir        in   1       0 = shift right, 1 = shift left; latched at start
//   loop       in   1       1 = reload and repeat after each pass; latched at start
//   div_cfg    in   DIV_W   shift every div_cfg+1 cycles; latched at start
//   ch0        out  1       control code bit 0 to registrador bank
//   ch1        out  1       control code bit 1 to registrador bank
//   step_cnt   out  clog2(WIDTH+1)  shifts completed in current pass
//   busy       out  1       high in LOAD/RUN/PAUSE
//   done       out  1       one-cycle pulse, single-pass completion
//   wrap       out  1       one-cycle pulse, pass completion in loop mode
// BEHAVIOUR
//   Codes {ch1,ch0}:
//     - 00 HOLD
//     - 01 LOAD
//     - 10 SHIFT RIGHT
//     - 11 SHIFT LEFT
//   Outputs: ch/busy/done/wrap are decodes of registered state only; no input->output path.
//   Reset: state=IDLE, ch=00, busy=0, done=0, wrap=0, step_cnt=0, presc=0, latched cfg=0.
//   FSM (one transition per clock):
//   - IDLE:
//     - ch=00.
//     - start=1 -> LOAD; latch dir, loop, div_cfg at that edge.
//   - LOAD:
//     - Exactly one cycle, ch=01.
//     - Clears step_cnt and presc.
//     - -> RUN. pause is ignored in LOAD.
//   - RUN:
//     - If presc==div_q:
//       - ch={1,dir_q} for this cycle (shift pulse); presc<=0; step_cnt+1.
//       - Else ch=00, presc+1.
//     - On the shift where step_cnt==WIDTH-1:
//       - Single pass: -> DONE.
//       - Loop: -> LOAD with wrap=1 that cycle.
//     - pause=1 and no shift this cycle -> PAUSE. A shift cycle completes first.
//   - PAUSE:
//     - ch=00; presc and step_cnt frozen.
//     - pause=0 -> RUN, resuming the same presc value.
//   - DONE:
//     - One cycle; done=1, busy=0, ch=00; step_cnt holds WIDTH.
//     - -> IDLE.
//   Latency (div_cfg=0):
//     - start at cycle t: LOAD at t+1, shifts at t+2..t+1+WIDTH, DONE at t+2+WIDTH.
//     - Next start is accepted in IDLE at t+3+WIDTH.
//   Priority: rst_n > stop > pause > start.
//     - stop in LOAD/RUN/PAUSE -> IDLE next edge, ch=00, no done/wrap, step_cnt held.
//     - stop in DONE is ignored.
//   Boundaries:
//     - start while busy: ignored.
//     - div_cfg/dir/loop changes mid-pass: ignored.
//     - presc wraps only via compare, never by overflow.
//     - Reset mid-pass: IDLE at next edge, bank receives ch=00.
// STRUCTURE
//   Shared include registrador_pkg.vh holds:
//     - CH_HOLD/CH_LOAD/CH_SHR/CH_SHL code localparams.
//     - FSM state encodings, used by the bank and this sequencer.
//   Sub-module tick_divider:
//     - DIV_W counter; inputs clear, enable, limit; output tick when count==limit.
//     - Used for presc.
// TESTING
//   1. Reset, div_cfg=0, dir=0, loop=0, start 1 cycle:
//      - ch=01 for 1 cycle, then 10 for 14 consecutive cycles.
//      - done pulse at t+16; step_cnt=14.
//   2. div_cfg=3, dir=1:
//      - ch=11 every 4th RUN cycle, 00 otherwise.
//      - 14 shift pulses total; done at t+2+56.
//   3. loop=1, div_cfg=0:
//      - wrap pulse plus a LOAD cycle every 15 cycles, done never set.
//      - stop -> IDLE next cycle, ch=00.
//   4. div_cfg=2, pause high for 10 cycles after 5 shifts:
//      - ch=00 and step_cnt=5 throughout the pause.
//      - Resumes with the same presc phase; total 14 shifts.
//   5. Simultaneous stop+pause in RUN -> IDLE. start during RUN -> ignored, no reload.
//   6. rst_n low mid-RUN at step 7:
//      - Next cycle ch=00, busy=0, step_cnt=0.
//      - A new start then replays case 1 exactly.

Source files
------------

// File: rtl/registrador_seq_pkg.sv
// Shared control codes and sequencer state encoding for the registrador bank.
package registrador_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    typedef logic [1:0] ch_code_t;

    localparam ch_code_t CH_HOLD = 2'b00;
    localparam ch_code_t CH_LOAD = 2'b01;
    localparam ch_code_t CH_SHR  = 2'b10;
    localparam ch_code_t CH_SHL  = 2'b11;

    function automatic ch_code_t shift_code(input logic dir);
        return dir ? CH_SHL : CH_SHR;
    endfunction

endpackage

// File: rtl/registrador_seq_tick_divider.sv
// Prescaler: counts enabled cycles and flags the cycle where the count equals the limit.
module registrador_seq_tick_divider #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [DIV_W-1:0] i_limit,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;

    assign o_tick = (r_cnt == i_limit);

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/registrador_seq.sv
// Sequencer producing the shared {ch1,ch0} code: one load cycle, then WIDTH shifts
// at a programmable rate, single-pass or looping.
module registrador_seq
    import registrador_seq_pkg::*;
#(
    parameter int WIDTH = 14,
    parameter int DIV_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       pause,
    input  logic                       dir,
    input  logic                       loop,
    input  logic [DIV_W-1:0]           div_cfg,
    output logic                       ch0,
    output logic                       ch1,
    output logic [$clog2(WIDTH+1)-1:0] step_cnt,
    output logic                       busy,
    output logic                       done,
    output logic                       wrap
);

    localparam int SW = $clog2(WIDTH + 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);

    seq_state_t       r_state;
    logic             r_dir;
    logic             r_loop;
    logic [DIV_W-1:0] r_div;
    logic [SW-1:0]    r_step;
    logic             r_wrap;
    logic             w_tick;
    ch_code_t         w_ch;

    registrador_seq_tick_divider #(.DIV_W(DIV_W)) u_presc (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (r_state == ST_LOAD),
        .i_enable (r_state == ST_RUN),
        .i_limit  (r_div),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_dir   <= 1'b0;
            r_loop  <= 1'b0;
            r_div   <= '0;
            r_step  <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_LOAD;
                        r_dir   <= dir;
                        r_loop  <= loop;
                        r_div   <= div_cfg;
                    end
                end
                ST_LOAD: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_step  <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A shift cycle always completes before a pause can take effect.
                    if (stop) begin
                        r_state <= ST_IDLE;
                    end else if (w_tick) begin
                        r_step <= r_step + 1'b1;
                        if (r_step == LAST_STEP) begin
                            if (r_loop) begin
                                r_state <= ST_LOAD;
                                r_wrap  <= 1'b1;
                            end else begin
                                r_state <= ST_DONE;
                            end
                        end
                    end else if (pause) begin
                        r_state <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                    end else if (!pause) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: w_ch gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_ch = CH_HOLD;
        case (r_state)
            ST_LOAD: w_ch = CH_LOAD;
            ST_RUN:  if (w_tick) w_ch = shift_code(r_dir);
            default: w_ch = CH_HOLD;
        endcase
    end

    assign {ch1, ch0} = w_ch;
    assign step_cnt   = r_step;
    assign busy       = (r_state == ST_LOAD) || (r_state == ST_RUN) || (r_state == ST_PAUSE);
    assign done       = (r_state == ST_DONE);
    assign wrap       = r_wrap;

endmodule

// File: tb/tb_registrador_seq.sv
// Scoreboard bench: a timing model of each pass queues expected output events,
// a negedge monitor pops and compares whenever the sequencer drives a non-idle output.
module tb_registrador_seq;

    localparam int WIDTH = 14;
    localparam int DIV_W = 8;
    localparam int SW    = $clog2(WIDTH + 1);
    localparam int NEVER = 32'h7fff_ffff;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, stop, pause, dir, loop;
    logic [DIV_W-1:0] div_cfg;
    logic             ch0, ch1, busy, done, wrap;
    logic [SW-1:0]    step_cnt;

    registrador_seq #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .dir      (dir),
        .loop     (loop),
        .div_cfg  (div_cfg),
        .ch0      (ch0),
        .ch1      (ch1),
        .step_cnt (step_cnt),
        .busy     (busy),
        .done     (done),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] ch;
        bit         done;
        bit         wrap;
        int         step;   // -1: not compared
    } ev_t;

    ev_t sb[$];
    ev_t mon_e;
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Expected events of a pass: LOAD at t+1, shift k at LOAD+k*(d+1), DONE one cycle after
    // the last shift (or a wrap+LOAD in loop mode). A pause entered on the first non-shift
    // RUN cycle c inside the pause window delays everything after c until the window closes.
    task automatic model_pass(input int t, input int d, input bit dr, input bit lp,
                              input int npass, input int stop_at,
                              input int ps, input int pe, output int pc);
        ev_t evs[$];
        ev_t e;
        int  per, l0, last;
        per  = 1 + WIDTH * (d + 1);
        l0   = t + 1;
        last = l0 + WIDTH * (d + 1);
        for (int p = 0; p < npass; p++) begin
            int l;
            l = t + 1 + p * per;
            e.cyc = l; e.ch = 2'b01; e.done = 1'b0; e.wrap = (p > 0) && lp; e.step = -1;
            evs.push_back(e);
            for (int k = 1; k <= WIDTH; k++) begin
                e.cyc = l + k * (d + 1); e.ch = dr ? 2'b11 : 2'b10;
                e.done = 1'b0; e.wrap = 1'b0; e.step = k - 1;
                evs.push_back(e);
            end
            if (!lp) begin
                e.cyc = l + WIDTH * (d + 1) + 1; e.ch = 2'b00;
                e.done = 1'b1; e.wrap = 1'b0; e.step = WIDTH;
                evs.push_back(e);
            end
        end
        pc = -1;
        for (int x = ps; x < pe; x++) begin
            if (x > l0 && x <= last && ((x - l0) % (d + 1)) != 0) begin
                pc = x;
                break;
            end
        end
        if (pc >= 0) begin
            foreach (evs[i]) if (evs[i].cyc > pc) evs[i].cyc += pe - pc;
        end
        foreach (evs[i]) if (evs[i].cyc <= stop_at) sb.push_back(evs[i]);
    endtask

    always @(negedge clk) begin
        if (mon_en && (ch0 || ch1 || done || wrap)) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {28'd0, ch1, ch0, done, wrap}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("ev_cycle", mon_e.cyc, cyc);
                check("ev_ch", {30'd0, ch1, ch0}, {30'd0, mon_e.ch});
                check("ev_done", {31'd0, done}, {31'd0, mon_e.done});
                check("ev_wrap", {31'd0, wrap}, {31'd0, mon_e.wrap});
                if (mon_e.step >= 0) check("ev_step_cnt", {28'd0, step_cnt}, mon_e.step);
            end
        end
    end

    // One pass: rel counts cycles from the start pulse; negative rel values disable a feature.
    task automatic run_pass(input int d, input bit dr, input bit lp, input int npass,
                            input int stop_rel, input int rst_rel,
                            input int ps_rel, input int plen, input int glitch_rel);
        int t, abort_rel, pc, pe_abs, stop_at;
        bit finished;
        t         = cyc;
        abort_rel = (stop_rel >= 0) ? stop_rel : rst_rel;
        stop_at   = (abort_rel >= 0) ? t + abort_rel : NEVER;
        pe_abs    = t + ps_rel + plen;
        model_pass(t, d, dr, lp, npass, stop_at, t + ps_rel, pe_abs, pc);
        finished = 1'b0;
        dir      = dr;
        loop     = lp;
        div_cfg  = DIV_W'(d);
        for (int rel = 0; rel < 600; rel++) begin
            start = (rel == 0) || (rel == glitch_rel);
            pause = (rel >= ps_rel) && (rel < ps_rel + plen);
            stop  = (rel == stop_rel);
            rst_n = (rel != rst_rel);
            if (rel > 0) begin
                dir     = 1'($urandom);
                loop    = 1'($urandom);
                div_cfg = DIV_W'($urandom);
            end
            @(negedge clk);
            if (pc >= 0 && cyc > pc && cyc <= pe_abs) begin
                check("pause_step_cnt", {28'd0, step_cnt}, (pc - (t + 1)) / (d + 1));
                check("pause_ch", {30'd0, ch1, ch0}, 32'd0);
                check("pause_busy", {31'd0, busy}, 32'd1);
            end
            if (abort_rel >= 0 && rel == abort_rel + 1) begin
                check("abort_busy", {31'd0, busy}, 32'd0);
                check("abort_ch", {30'd0, ch1, ch0}, 32'd0);
                check("abort_done_wrap", {30'd0, done, wrap}, 32'd0);
                if (rst_rel >= 0) check("reset_step_cnt", {28'd0, step_cnt}, 32'd0);
            end
            @(posedge clk);
            #1;
            if (abort_rel >= 0 && rel == abort_rel + 1) begin
                finished = 1'b1;
                break;
            end
            if (abort_rel < 0 && rel > 0 && sb.size() == 0) begin
                finished = 1'b1;
                break;
            end
        end
        check("pass_finished", {31'd0, finished}, 32'd1);
        check("scoreboard_drained", sb.size(), 32'd0);
        sb.delete();
        start = 1'b0;
        stop  = 1'b0;
        pause = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        pause   = 1'b0;
        dir     = 1'b0;
        loop    = 1'b0;
        div_cfg = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ch", {30'd0, ch1, ch0}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done_wrap", {30'd0, done, wrap}, 32'd0);
        check("reset_step_cnt", {28'd0, step_cnt}, 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // basic single pass, then slow left shift
        run_pass(0, 1'b0, 1'b0, 1, -1, -1, 0, 0, -1);
        run_pass(3, 1'b1, 1'b0, 1, -1, -1, 0, 0, -1);
        // looping: wraps every 15 cycles, stopped in the third pass
        run_pass(0, 1'b0, 1'b1, 3, 1 + 15 * 2 + 5, -1, 0, 0, -1);
        // pause for 10 cycles right after the fifth shift
        run_pass(2, 1'b0, 1'b0, 1, -1, -1, 17, 10, -1);
        // start ignored mid-run, then stop and pause together
        run_pass(1, 1'b0, 1'b0, 1, 9, -1, 9, 1, 6);
        // reset at step 7, then replay the basic pass
        run_pass(0, 1'b0, 1'b0, 1, -1, 9, 0, 0, -1);
        run_pass(0, 1'b0, 1'b0, 1, -1, -1, 0, 0, -1);

        for (int i = 0; i < 8; i++) begin
            run_pass($urandom_range(0, 4), 1'($urandom), 1'b0, 1, -1, -1,
                     $urandom_range(1, 40), $urandom_range(0, 8), $urandom_range(2, 12));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
